// File: rtl/lms_fir_mac.sv
// Sequential single-multiplier FIR: one sample per handshake, TAPS MAC cycles, full-precision result out.
// States: IDLE = waiting for a sample | MAC = one tap per cycle | OUT = result held until taken.
module lms_fir_mac #(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_FRAC   = 15,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC  = 15,
  parameter int TAPS       = 8,
  parameter int ACC_WIDTH  = DIN_WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN_WIDTH-1:0]  in_data,
  input  logic                         coef_we,
  input  logic [$clog2(TAPS):0]        coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  out_data,
  output logic                         busy
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = DIN_WIDTH + COEF_WIDTH;
  localparam logic [AW:0]   TAPS_A   = (AW+1)'(TAPS);
  localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

  if (TAPS < 2 || DIN_FRAC >= DIN_WIDTH || COEF_FRAC >= COEF_WIDTH ||
      ACC_WIDTH != PW + AW) begin : g_param_check
    $error("lms_fir_mac: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                       state_q;
  logic signed [DIN_WIDTH-1:0]  x_q     [TAPS];
  logic signed [COEF_WIDTH-1:0] c_sh_q  [TAPS];
  logic signed [COEF_WIDTH-1:0] c_act_q [TAPS];
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, out_data_q;
  logic [AW-1:0]                idx_q;
  logic signed [PW-1:0]         prod;
  logic                         coef_ok;

  assign coef_ok = coef_we && (coef_addr < TAPS_A);
  assign prod    = x_q[idx_q] * c_act_q[idx_q];
  assign acc_d   = acc_q + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  // in_ready is gated by rst so nothing is offered while reset is held
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      out_data_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i]     <= '0;
        c_sh_q[i]  <= '0;
        c_act_q[i] <= '0;
      end
    end else begin
      if (coef_ok) c_sh_q[coef_addr[AW-1:0]] <= coef_data;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q[0] <= in_data;
            for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
            // a write landing on the accept edge goes straight into the active bank
            for (int i = 0; i < TAPS; i++)
              c_act_q[i] <= (coef_ok && coef_addr == (AW+1)'(i)) ? coef_data : c_sh_q[i];
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            out_data_q <= acc_d;
            state_q    <= OUT;
          end
        end
        OUT: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_fir_mac.sv
// Scoreboard bench for lms_fir_mac: directed samples push expected results, a monitor pops on handshake.
module tb_lms_fir_mac;
  localparam int TAPS = 8;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int AW   = $clog2(TAPS);
  localparam int ACCW = DW + CW + AW;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [DW-1:0]   in_data = '0;
  logic                   coef_we = 1'b0;
  logic [AW:0]            coef_addr = '0;
  logic signed [CW-1:0]   coef_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic signed [ACCW-1:0] out_data;
  logic                   busy;

  int     pass_cnt = 0;
  int     total_cnt = 0;
  longint cyc = 0;

  typedef struct {
    longint data;
    longint acc_cyc;
  } exp_t;
  exp_t sb[$];

  lms_fir_mac #(.DIN_WIDTH(DW), .DIN_FRAC(15), .COEF_WIDTH(CW), .COEF_FRAC(15), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: latency on out_valid rise, data on handshake
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
        else check("latency", cyc - sb[0].acc_cyc, TAPS);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
      end
      prev_valid <= out_valid;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic coef_wr(input int a, input logic [CW-1:0] d);
    coef_we = 1'b1;
    coef_addr = (AW+1)'(a);
    coef_data = d;
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  task automatic accept(input logic [DW-1:0] d, input bit push, input longint exp);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    if (push) sb.push_back('{data: exp, acc_cyc: cyc});
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    check("drain_idle", longint'(sb.size() != 0 || busy), 0);
  endtask

  longint imp_exp [8] = '{'h4000, 'h8000, 'hC000, 'h10000, 'h14000, 'h18000, 'h1C000, 'h20000};
  longint ext_exp [8] = '{'h4000_0000, 'h8000_0000, 'hC000_0000, 'h1_0000_0000,
                          'h1_4000_0000, 'h1_8000_0000, 'h1_C000_0000, 'h2_0000_0000};

  initial begin
    logic signed [ACCW-1:0] held;
    bit ok_v, ok_d, ok_r, seen;
    int n;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    // impulse response
    for (int k = 0; k < TAPS; k++) coef_wr(k, 16'(k + 1));
    for (int k = 0; k < TAPS; k++) begin
      accept((k == 0) ? 16'h4000 : 16'h0000, 1'b1, imp_exp[k]);
      drain();
    end

    // extreme values
    do_reset();
    for (int k = 0; k < TAPS; k++) coef_wr(k, 16'h8000);
    for (int k = 0; k < TAPS; k++) begin
      accept(16'h8000, 1'b1, ext_exp[k]);
      drain();
    end

    // backpressure
    do_reset();
    coef_wr(0, 16'h0001);
    out_ready = 1'b0;
    accept(16'h0123, 1'b1, 'h123);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("bp_valid_seen", out_valid, 1);
    held = out_data;
    ok_v = 1; ok_d = 1; ok_r = 1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!out_valid) ok_v = 0;
      if (out_data !== held) ok_d = 0;
      if (in_ready) ok_r = 0;
    end
    check("bp_valid_held", ok_v, 1);
    check("bp_data_stable", ok_d, 1);
    check("bp_in_ready_low", ok_r, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_after_valid", out_valid, 0);
    check("bp_after_busy", busy, 0);
    check("bp_after_in_ready", in_ready, 1);
    check("bp_sb_empty", sb.size(), 0);

    // coefficient timing
    do_reset();
    coef_wr(0, 16'h0002);
    accept(16'h0100, 1'b1, 'h200);
    coef_wr(0, 16'h7FFF);
    drain();
    coef_we = 1'b1;
    coef_addr = '0;
    coef_data = 16'h0003;
    accept(16'h0010, 1'b1, 'h30);
    drain();
    coef_wr(TAPS, 16'h1111);
    accept(16'h0001, 1'b1, 3);
    drain();

    // reset in the middle of a MAC
    do_reset();
    for (int k = 0; k < TAPS; k++) coef_wr(k, 16'h0001);
    accept(16'h1000, 1'b1, 'h1000);
    drain();
    accept(16'h2000, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1;
    end
    check("midrst_no_result", seen, 0);
    for (int k = 0; k < TAPS; k++) coef_wr(k, 16'h0001);
    accept(16'h0005, 1'b1, 5);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
